// File: rtl/riscv_dm_pkg.sv
// Encodings, FSM state type and helpers shared by the MEM-stage data-memory controller.
package riscv_dm_pkg;

   localparam logic [2:0] RdNone = 3'b000;
   localparam logic [2:0] RdLb   = 3'b001;
   localparam logic [2:0] RdLh   = 3'b010;
   localparam logic [2:0] RdLw   = 3'b011;
   localparam logic [2:0] RdLbu  = 3'b100;
   localparam logic [2:0] RdLhu  = 3'b101;

   localparam logic [1:0] WrNone = 2'b00;
   localparam logic [1:0] WrSb   = 2'b01;
   localparam logic [1:0] WrSh   = 2'b10;
   localparam logic [1:0] WrSw   = 2'b11;

   localparam int unsigned TimeoutCntW = 8;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDone
   } dm_state_e;

   // 110/111 fall outside the load range and count as no load.
   function automatic logic is_load(input logic [2:0] r_dm);
      return (r_dm != RdNone) && (r_dm <= RdLhu);
   endfunction

   // A store takes precedence, so only its size matters when both are present.
   function automatic logic is_misaligned(input logic [2:0] r_dm, input logic [1:0] w_dm,
                                          input logic [1:0] off);
      logic half;
      logic word;
      if (w_dm != WrNone) begin
         half = (w_dm == WrSh);
         word = (w_dm == WrSw);
      end else begin
         half = (r_dm == RdLh) || (r_dm == RdLhu);
         word = (r_dm == RdLw);
      end
      return (half && off[0]) || (word && (off != 2'b00));
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Store lane replication and byte strobes; load byte/half extraction with sign/zero extension.
module dm_lane_align
   import riscv_dm_pkg::*;
(
   input  logic [1:0]  st_type,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_wstrb,
   input  logic [2:0]  ld_type,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      st_wdata = '0;
      st_wstrb = '0;
      case (st_type)
         WrSb: begin
            st_wdata = {4{st_data[7:0]}};
            st_wstrb = 4'b0001 << st_off;
         end
         WrSh: begin
            st_wdata = {2{st_data[15:0]}};
            st_wstrb = st_off[1] ? 4'b1100 : 4'b0011;
         end
         WrSw: begin
            st_wdata = st_data;
            st_wstrb = 4'b1111;
         end
         default: ;
      endcase
   end

   assign ld_byte = ld_word[{ld_off, 3'b000} +: 8];
   assign ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

   always_comb begin
      ld_data = '0;
      case (ld_type)
         RdLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         RdLh:    ld_data = {{16{ld_half[15]}}, ld_half};
         RdLw:    ld_data = ld_word;
         RdLbu:   ld_data = {24'b0, ld_byte};
         RdLhu:   ld_data = {16'b0, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: request/acknowledge transaction with pipeline stall,
// misalignment rejection and ack timeout.
module dm_access_ctrl
   import riscv_dm_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  r_dm,
   input  logic [1:0]  w_dm,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic [31:0] load_data,
   output logic        misalign,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [TimeoutCntW-1:0] TimeoutVal = TimeoutCntW'(TIMEOUT);

   dm_state_e              state_q, state_d;
   logic [TimeoutCntW-1:0] cnt_q, cnt_d;
   logic [31:0]            mem_addr_q, mem_wdata_q, load_data_q;
   logic                   mem_we_q;
   logic [3:0]             mem_wstrb_q;
   logic [2:0]             ld_type_q;
   logic [1:0]             ld_off_q;

   logic        is_store, req, mis, start, ld_upd;
   logic [31:0] st_wdata, ld_data;
   logic [3:0]  st_wstrb;

   assign is_store = (w_dm != WrNone);
   assign req      = is_store || is_load(r_dm);
   assign mis      = is_misaligned(r_dm, w_dm, addr[1:0]);

   dm_lane_align u_lane_align (
      .st_type  (w_dm),
      .st_off   (addr[1:0]),
      .st_data  (wdata),
      .st_wdata (st_wdata),
      .st_wstrb (st_wstrb),
      .ld_type  (ld_type_q),
      .ld_off   (ld_off_q),
      .ld_word  (mem_rdata),
      .ld_data  (ld_data)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy     = 1'b0;
      misalign = 1'b0;
      bus_err  = 1'b0;
      mem_req  = 1'b0;
      start    = 1'b0;
      ld_upd   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (mis) begin
                  misalign = 1'b1;
               end else begin
                  busy    = 1'b1;
                  start   = 1'b1;
                  cnt_d   = '0;
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            // Ack wins over a timeout landing in the same cycle.
            if (mem_ack) begin
               ld_upd  = (ld_type_q != RdNone);
               state_d = StDone;
            end else if (cnt_q == TimeoutVal) begin
               bus_err = 1'b1;
               state_d = StDone;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         ld_type_q   <= RdNone;
         ld_off_q    <= '0;
         load_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (start) begin
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_we_q    <= is_store;
            mem_wdata_q <= st_wdata;
            mem_wstrb_q <= st_wstrb;
            ld_type_q   <= is_store ? RdNone : r_dm;
            ld_off_q    <= addr[1:0];
         end
         if (ld_upd) begin
            load_data_q <= ld_data;
         end
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign load_data = load_data_q;

endmodule
